// File: rtl/stack_pkg.sv
// stack_pkg: shared op encoding and default geometry for lifo_stack
package stack_pkg;
  localparam int STACK_WIDTH = 18;
  localparam int STACK_DEPTH = 4;
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b10,
    OP_POP  = 2'b01,
    OP_XCHG = 2'b11
  } stack_op_e;
endpackage

// File: rtl/lifo_stack_mem.sv
// lifo_stack_mem: unreset register array, one sync write port, two async read ports
module lifo_stack_mem #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_a_i,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_a_o,
  output logic [WIDTH-1:0] rdata_b_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  // write the addressed entry; contents survive reset
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];
endmodule

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised LIFO with exchange, peek and status; STACK_ERR_EN enables sticky ovf/unf flags
module lifo_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic [WIDTH-1:0] top,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             ovf_err,
  output logic             unf_err
);
  localparam int CW = AW + 1;
  stack_op_e        op;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_vld_q;
  logic [AW-1:0]    wr_ptr, top_idx, waddr;
  logic             push_ok, pop_ok, xchg_ok, we, ovf_evt, unf_evt;
  logic [WIDTH-1:0] rd_top, rd_dout;
  // decode the op and derive next pointer, write address and error events
  always_comb begin
    op      = stack_op_e'({push, pop});
    wr_ptr  = count_q[AW-1:0];
    top_idx = wr_ptr - AW'(1);
    xchg_ok = op == OP_XCHG && !empty;
    push_ok = (op == OP_PUSH && !full) || (op == OP_XCHG && empty);
    pop_ok  = op == OP_POP && !empty;
    we      = push_ok || xchg_ok;
    waddr   = xchg_ok ? top_idx : wr_ptr;
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    dout_d  = (pop_ok || xchg_ok) ? rd_dout : dout_q;
    ovf_evt = op == OP_PUSH && full;
    unf_evt = (op == OP_POP || op == OP_XCHG) && empty;
  end
  lifo_stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk       (clk),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (din),
    .raddr_a_i (top_idx),
    .raddr_b_i (top_idx),
    .rdata_a_o (rd_top),
    .rdata_b_o (rd_dout)
  );
  // pointer and popped-data registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count_q    <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      dout_q     <= dout_d;
      dout_vld_q <= pop_ok || xchg_ok;
    end
  assign count    = count_q;
  assign empty    = count_q == '0;
  assign full     = count_q == CW'(DEPTH);
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign top      = empty ? '0 : rd_top;
`ifdef STACK_ERR_EN
  logic ovf_q, unf_q;
  // sticky error flags; a new event beats a simultaneous clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_evt || (ovf_q && !err_clr);
      unf_q <= unf_evt || (unf_q && !err_clr);
    end
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
`else
  logic unused_err;
  assign unused_err = err_clr ^ ovf_evt ^ unf_evt;
  assign ovf_err    = 1'b0;
  assign unf_err    = 1'b0;
`endif
endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed plus random stimulus against a queue-based LIFO model
module tb_lifo_stack;
  localparam int W = 18;
  localparam int D = 4;
  localparam int AW = $clog2(D);
`ifdef STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, push = 1'b0, pop = 1'b0, err_clr = 1'b0;
  logic [W-1:0] din = '0, dout, top;
  logic [AW:0] count;
  logic dout_vld, empty, full, ovf_err, unf_err;
  int total = 0, bad = 0;
  logic [W-1:0] m_s[$];
  logic [W-1:0] m_dout;
  logic m_vld, m_ovf, m_unf;
  lifo_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din), .err_clr(err_clr),
    .dout(dout), .dout_vld(dout_vld), .top(top), .count(count), .empty(empty),
    .full(full), .ovf_err(ovf_err), .unf_err(unf_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic m_reset();
    m_s.delete();
    m_dout = '0;
    m_vld = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask
  task automatic m_step(input logic p, input logic q, input logic [W-1:0] d, input logic c);
    bit ov = 0, un = 0;
    m_vld = 1'b0;
    if (p && !q) begin
      if (m_s.size() < D) m_s.push_back(d); else ov = 1;
    end else if (!p && q) begin
      if (m_s.size() > 0) begin m_dout = m_s.pop_back(); m_vld = 1'b1; end else un = 1;
    end else if (p && q) begin
      if (m_s.size() > 0) begin
        m_dout = m_s[m_s.size()-1];
        m_s[m_s.size()-1] = d;
        m_vld = 1'b1;
      end else begin
        m_s.push_back(d);
        un = 1;
      end
    end
    if (ERR_EN) begin
      m_ovf = ov || (m_ovf && !c);
      m_unf = un || (m_unf && !c);
    end
  endtask
  task automatic check_all(input string ph);
    chk({ph, ".count"}, 32'(count), 32'(m_s.size()));
    chk({ph, ".empty"}, 32'(empty), 32'(m_s.size() == 0));
    chk({ph, ".full"}, 32'(full), 32'(m_s.size() == D));
    chk({ph, ".top"}, 32'(top), m_s.size() > 0 ? 32'(m_s[m_s.size()-1]) : 32'd0);
    chk({ph, ".dout"}, 32'(dout), 32'(m_dout));
    chk({ph, ".vld"}, 32'(dout_vld), 32'(m_vld));
    chk({ph, ".ovf"}, 32'(ovf_err), 32'(m_ovf));
    chk({ph, ".unf"}, 32'(unf_err), 32'(m_unf));
  endtask
  task automatic step(input string ph, input logic p, input logic q, input logic [W-1:0] d, input logic c);
    push = p; pop = q; din = d; err_clr = c;
    @(posedge clk);
    m_step(p, q, d, c);
    #1;
    check_all(ph);
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask
  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) step("fill", 1, 0, W'(i), 0);
    chk("plan_top4", 32'(top), 32'd4);
    step("ovf_push", 1, 0, 18'h3FFFF, 0);
    chk("plan_top_kept", 32'(top), 32'd4);
    for (int i = 0; i < 4; i++) step("drain", 0, 1, '0, 0);
    chk("plan_last_pop", 32'(dout), 32'd1);
    step("unf_pop", 0, 1, '0, 0);
    step("clr", 0, 0, '0, 1);
    step("clr_evt", 0, 1, '0, 1);
    step("push_a", 1, 0, 18'h0000A, 0);
    step("xchg_b", 1, 1, 18'h0000B, 0);
    chk("plan_xchg_dout", 32'(dout), 32'hA);
    step("xchg_empty_pre", 0, 1, '0, 1);
    step("xchg_empty", 1, 1, 18'h00077, 1);
    for (int i = 0; i < 3; i++) step("refill", 1, 0, W'(18'h100 + i), 1);
    step("xchg_full", 1, 1, 18'h00055, 0);
    step("pop_after_xchg", 0, 1, '0, 0);
    step("clr2", 0, 0, '0, 1);
    while (m_s.size() > 0) step("flush", 0, 1, '0, 0);
    for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, W'(18'h200 + i), 0);
    step("pop_pre_rst", 0, 1, '0, 0);
    #3;
    rst = 1'b1;
    #1;
    m_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 1, 0, 18'h00321, 0);
    step("post_rst_pop", 0, 1, '0, 0);
    for (int n = 0; n < 400; n++) begin
      int r = $urandom_range(0, 99);
      logic p = r < 45 || r >= 85;
      logic q = (r >= 40 && r < 80) || r >= 85;
      step("rand", p, q, W'($urandom), $urandom_range(0, 9) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
